// File: rtl/param_loader_pkg.sv
// rtl/param_loader_pkg.sv - Shared defines for the parameter loader: word/address types, write width, FSM states
// Contents: param_t, param_addr_t, param_len_t, data_width_t, SINGLE_WIDTH, ld_state_t, burst_fits().
// Option: PARAM_LOADER_CHECKSUM_EN adds the ST_CHECK state.
package param_loader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LEN_W  = ADDR_W + 1;

  typedef logic [DATA_W-1:0] param_t;
  typedef logic [ADDR_W-1:0] param_addr_t;
  typedef logic [LEN_W-1:0]  param_len_t;
  typedef logic [1:0]        data_width_t;

  localparam data_width_t SINGLE_WIDTH = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
`ifdef PARAM_LOADER_CHECKSUM_EN
    ,
    ST_CHECK  = 2'd3
`endif
  } ld_state_t;

  // A burst fits when its last word lands at depth-1 or below; done in 32 bits so it cannot wrap.
  function automatic logic burst_fits(input param_addr_t addr, input param_len_t len,
                                      input int unsigned depth);
    return (32'(addr) + 32'(len)) <= depth;
  endfunction

endpackage

// File: rtl/param_loader_if.sv
// rtl/param_loader_if.sv - Control, word-stream and memory-write bundle of the parameter loader
// Signals: start/start_addr/length/abort (control), in_valid/in_ready/in_data (word stream),
//   wr_en/wr_chip_en/wr_addr/wr_data/wr_data_width (memory write port), busy/done/err/chk_ok/chk_fail (status).
// Modports: master = controller/stream source side, slave = loader side.
interface param_loader_if;
  import param_loader_pkg::*;

  logic        start;
  param_addr_t start_addr;
  param_len_t  length;
  logic        abort;

  logic        in_valid;
  logic        in_ready;
  param_t      in_data;

  logic        wr_en;
  logic        wr_chip_en;
  param_addr_t wr_addr;
  param_t      wr_data;
  data_width_t wr_data_width;

  logic        busy;
  logic        done;
  logic        err;
  logic        chk_ok;
  logic        chk_fail;

  modport master (
    output start, start_addr, length, abort, in_valid, in_data,
    input  in_ready, wr_en, wr_chip_en, wr_addr, wr_data, wr_data_width,
    input  busy, done, err, chk_ok, chk_fail
  );

  modport slave (
    input  start, start_addr, length, abort, in_valid, in_data,
    output in_ready, wr_en, wr_chip_en, wr_addr, wr_data, wr_data_width,
    output busy, done, err, chk_ok, chk_fail
  );

endinterface

// File: rtl/param_loader.sv
// rtl/param_loader.sv - Loads a burst of streamed parameter words into consecutive parameter-memory addresses
// Ports: clk; rst_n (asynchronous, active-low); bus (param_loader_if.slave) carrying the start/abort control,
//   the in_* word stream, the wr_* memory write port and busy/done/err/chk_ok/chk_fail status pulses.
// Option: PARAM_LOADER_CHECKSUM_EN - accumulate a word sum and compare it with one trailing checksum word.
module param_loader
  import param_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 1 << ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  param_loader_if.slave bus
);

  ld_state_t   state_q, state_d;
  param_addr_t base_q;
  param_len_t  len_q;
  param_len_t  cnt_q;

  logic        wr_en_q;
  param_addr_t wr_addr_q;
  param_t      wr_data_q;
  logic        done_q;
  logic        err_q;

  logic        in_ready;
  logic        busy;
  logic        accept;
  logic        last_word;
  logic        start_ok;

`ifdef PARAM_LOADER_CHECKSUM_EN
  param_t      sum_q;
  logic        chk_seen_q;
  logic        chk_match_q;
  logic        chk_ok_q;
  logic        chk_fail_q;
`endif

  assign start_ok  = burst_fits(bus.start_addr, bus.length, DEPTH);
  assign accept    = bus.in_valid & in_ready;
  assign last_word = (cnt_q + param_len_t'(1)) == len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        // start outranks a simultaneous abort; abort alone is meaningless here
        if (bus.start) begin
          if (!start_ok)                state_d = ST_IDLE;
          else if (bus.length == '0)    state_d = ST_FINISH;
          else                          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (bus.abort) state_d = ST_IDLE;
        else if (accept && last_word) begin
`ifdef PARAM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_FINISH;
`endif
        end
      end
`ifdef PARAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        in_ready = 1'b1;
        if (bus.abort)   state_d = ST_IDLE;
        else if (accept) state_d = ST_FINISH;
      end
`endif
      ST_FINISH: state_d = ST_IDLE;
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write port and status pulses are registered: a word accepted on one edge is written on the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      chk_seen_q  <= 1'b0;
      chk_match_q <= 1'b0;
      chk_ok_q    <= 1'b0;
      chk_fail_q  <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
      chk_ok_q   <= 1'b0;
      chk_fail_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            base_q <= bus.start_addr;
            len_q  <= bus.length;
            cnt_q  <= '0;
            if (!start_ok) err_q <= 1'b1;
`ifdef PARAM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            chk_seen_q  <= 1'b0;
            chk_match_q <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          // a word handed over in the abort cycle itself is still written
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= base_q + cnt_q[ADDR_W-1:0];
            wr_data_q <= bus.in_data;
            cnt_q     <= cnt_q + param_len_t'(1);
`ifdef PARAM_LOADER_CHECKSUM_EN
            sum_q     <= sum_q + bus.in_data;
`endif
          end
          if (bus.abort) err_q <= 1'b1;
        end
`ifdef PARAM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          // the checksum word is consumed but never written to memory
          if (accept) begin
            chk_seen_q  <= 1'b1;
            chk_match_q <= (bus.in_data == sum_q);
          end
          if (bus.abort) err_q <= 1'b1;
        end
`endif
        ST_FINISH: begin
          done_q <= 1'b1;
`ifdef PARAM_LOADER_CHECKSUM_EN
          // zero-length bursts skip CHECK, so chk_seen_q gates the verdict
          chk_ok_q   <= chk_seen_q & chk_match_q;
          chk_fail_q <= chk_seen_q & ~chk_match_q;
          err_q      <= chk_seen_q & ~chk_match_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.busy          = busy;
  assign bus.wr_chip_en    = busy;
  assign bus.wr_en         = wr_en_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.wr_data_width = SINGLE_WIDTH;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
`ifdef PARAM_LOADER_CHECKSUM_EN
  assign bus.chk_ok        = chk_ok_q;
  assign bus.chk_fail      = chk_fail_q;
`else
  assign bus.chk_ok        = 1'b0;
  assign bus.chk_fail      = 1'b0;
`endif

endmodule

// File: doc/param_loader.md
PARAM_LOADER -- requirements
Module: param_loader

Interface
REQ-001 Parameter DEPTH, default 2^width(ParamAddr_t), number of addressable parameter words.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse that requests a load burst.
REQ-005 start_addr  input  ParamAddr_t  first write address, sampled on accepted start.
REQ-006 length  input  ParamAddr_t+1 bits  number of parameter words, sampled on accepted start.
REQ-007 abort  input  1  cancels the burst in progress.
REQ-008 in_valid / in_ready / in_data  input / output / input  1 / 1 / Param_t  upstream word stream.
REQ-009 wr_en, wr_chip_en, wr_addr, wr_data, wr_data_width  outputs  1, 1, ParamAddr_t, Param_t, DataWidth_t  drive the parameter-memory write port.
REQ-010 busy, done, err  output  1 each  status; done and err are one-cycle pulses.
REQ-011 chk_ok, chk_fail  output  1 each  checksum result pulses (see Configuration).

Function
REQ-012 FSM states: IDLE, LOAD, CHECK (macro only), FINISH.
REQ-013 IDLE + start: transition to LOAD, latch start_addr and length, clear word counter.
REQ-014 start while not IDLE: ignored, no state change.
REQ-015 start with length 0: go to FINISH, no wr_en issued.
REQ-016 start with start_addr+length > DEPTH: stay IDLE, pulse err next cycle, no writes.
REQ-017 in_ready = 1 only in LOAD (and CHECK); 0 in IDLE, FINISH and during reset.
REQ-018 Word accepted on a cycle with in_valid & in_ready.
REQ-019 Word accepted at cycle t: wr_en = 1 at t+1 with wr_data = that word and wr_addr = latched start_addr + index; one cycle of latency, registered outputs.
REQ-020 wr_chip_en = busy.
REQ-021 wr_data_width = SINGLE_WIDTH constantly.
REQ-022 wr_en = 0 on every cycle with no accepted word the previous cycle; in_valid gaps cause no writes.
REQ-023 Sustained throughput: one word per cycle.
REQ-024 After the length-th word is accepted, in_ready drops the next cycle; enter CHECK if compiled, else FINISH.
REQ-025 FINISH: pulse done for one cycle, then return to IDLE; busy = 1 in LOAD, CHECK and FINISH.
REQ-026 abort in LOAD/CHECK: next state IDLE and in_ready = 0 next cycle.
REQ-027 On abort, a write already registered from the prior cycle still completes; no done pulse, err pulses once.
REQ-028 abort and start in the same cycle while IDLE: start wins; abort in IDLE is ignored.
REQ-029 Address never wraps; guaranteed by REQ-016.

Reset
REQ-030 rst_n low asynchronously forces state IDLE; all outputs 0 (wr_data_width = SINGLE_WIDTH); counters, latches and checksum cleared.
REQ-031 Reset mid-burst discards the burst; no done, err, chk_ok or chk_fail pulse after release.

Configuration
REQ-032 Macro PARAM_LOADER_CHECKSUM_EN defined: sum of all loaded words modulo 2^width(Param_t) is accumulated.
REQ-033 With the macro, CHECK accepts one extra word as expected checksum, writes nothing, then pulses chk_ok on match or chk_fail and err on mismatch, concurrent with done.
REQ-034 Macro undefined: no CHECK state, no accumulator; chk_ok and chk_fail tied 0.

Structure
REQ-035 The FSM state enum and SINGLE_WIDTH come from the shared Defines package, alongside Param_t, ParamAddr_t and DataWidth_t.
REQ-036 The block is a single module with no sub-modules; it instantiates directly upstream of params_mem's write port.

Verification
REQ-037 start_addr=0, length=4, words 0x0001..0x0004 back-to-back -> wr_en on 4 consecutive cycles, addr 0..3, data 1..4, done 1 cycle after last write.
REQ-038 start_addr=10, length=3, in_valid toggling 1,0,1,0,1 -> exactly 3 writes at addr 10,11,12, no write on gap cycles.
REQ-039 start_addr=DEPTH-2, length=3 -> err pulse, wr_en never asserted, busy stays 0.
REQ-040 length=8, abort after 3rd accepted word -> writes at addr 0..2 only, err pulse, no done, in_ready 0 thereafter.
REQ-041 Macro on, words 0x0010, 0x0020, then checksum 0x0030 -> chk_ok + done; repeat with 0x0031 -> chk_fail + err + done, 2 writes in each run.
REQ-042 rst_n asserted mid-burst (after 2 of 5 words) -> outputs 0 immediately; after release, start length=1 completes normally.
